disp_scan_mux: RTL and testbench

Multi-digit display scanner that sits directly upstream of the 4-bit seven-segment decoder. It holds a double-buffered set of N BCD digits and time-multiplexes them, presenting one 4-bit digit code per slot to the single shared decoder together with a one-hot digit enable. It adds leading-zero blanking and per-digit blinking for the game's score and level display. Blanking is expressed as code 4'hF, which the decoder renders as all segments off.

---
 rtl/disp_scan_mux_pkg.sv | 16 +
 rtl/disp_scan_mux_tick_div.sv | 33 +++
 rtl/disp_scan_mux.sv | 135 +++++++++++++
 tb/tb_disp_scan_mux.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/disp_scan_mux_pkg.sv
// Shared constants for the display scanner and the seven-segment decoder.
// BLANK_CODE is the code the decoder renders as all segments off.
package disp_scan_mux_pkg;
  localparam int DIGIT_W          = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam int DEF_N_DIGITS     = 4;
  localparam int DEF_SCAN_DIV     = 50000;
  localparam int DEF_BLINK_FRAMES = 64;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Counter width that stays legal when the divide ratio is 1.
  function automatic int cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/disp_scan_mux_tick_div.sv
// tick_div: enable-gated prescaler. Counts enabled cycles 0..DIV-1 and wraps.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   en_i   count enable
//   tc_o   high in the enabled cycle whose edge wraps the count (terminal count)
module tick_div
  import disp_scan_mux_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/disp_scan_mux.sv
// disp_scan_mux: time-multiplexes N BCD digits onto one shared seven-segment
// decoder, with double buffering, leading-zero blanking and per-digit blink.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   load_i           strobe: capture digits_in_i / blink_mask_i into shadow
//   digits_in_i      packed digit codes, digit 0 in the low nibble
//   blink_mask_i     per-digit blink enable
//   lzb_en_i         leading-zero blanking enable (sampled live)
//   digit_code_o     code for the current slot (registered)
//   digit_en_o       one-hot digit enable, zero in each slot's guard cycle
//   frame_start_o    one-cycle pulse in the first cycle of slot 0
//   pending_o        shadow holds data not yet applied to the active buffer
module disp_scan_mux
  import disp_scan_mux_pkg::*;
#(
  parameter int N_DIGITS     = DEF_N_DIGITS,
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [DIGIT_W*N_DIGITS-1:0]   digits_in_i,
  input  logic [N_DIGITS-1:0]           blink_mask_i,
  input  logic                          lzb_en_i,
  output logic [DIGIT_W-1:0]            digit_code_o,
  output logic [N_DIGITS-1:0]           digit_en_o,
  output logic                          frame_start_o,
  output logic                          pending_o
);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [N_DIGITS-1:0][DIGIT_W-1:0] shd_dig_q, shd_dig_d, act_dig_q, act_dig_d;
  logic [N_DIGITS-1:0]              shd_msk_q, shd_msk_d, act_msk_q, act_msk_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             blink_q, blink_d;
  logic                             pending_q, pending_d;
  logic [DIGIT_W-1:0]               code_q, code_d;
  logic [N_DIGITS-1:0]              en_q, en_d;
  logic                             fs_q;
  logic                             scan_tc, frame_edge, blink_tc;
  logic                             upper_zero;
  digit_t                           sel_code;

  tick_div #(.DIV(SCAN_DIV)) u_scan (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .tc_o  (scan_tc)
  );

  // Counts frames; terminal count flips the blink phase.
  tick_div #(.DIV(BLINK_FRAMES)) u_blink (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (frame_edge),
    .tc_o  (blink_tc)
  );

  assign frame_edge = scan_tc && (idx_q == IDX_LAST);

  always_comb begin
    idx_d     = idx_q;
    if (scan_tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    blink_d   = blink_q ^ blink_tc;

    act_dig_d = act_dig_q;
    act_msk_d = act_msk_q;
    if (frame_edge && pending_q) begin
      act_dig_d = shd_dig_q;
      act_msk_d = shd_msk_q;
    end

    shd_dig_d = shd_dig_q;
    shd_msk_d = shd_msk_q;
    pending_d = pending_q;
    if (frame_edge) pending_d = 1'b0;
    if (load_i) begin
      shd_dig_d = digits_in_i;
      shd_msk_d = blink_mask_i;
      pending_d = 1'b1;
    end
  end

  // Code for the slot being entered, taken from the buffer and blink phase
  // that will be in force during that slot.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(idx_d) && act_dig_d[i] != '0) upper_zero = 1'b0;
    end
    sel_code = act_dig_d[idx_d];
    if (blink_d && act_msk_d[idx_d])                  sel_code = BLANK_CODE;
    else if (lzb_en_i && idx_d != '0 && upper_zero)   sel_code = BLANK_CODE;
  end

  always_comb begin
    code_d = scan_tc ? sel_code : code_q;
    // Next cycle is a guard cycle exactly when the prescaler wraps now.
    en_d   = scan_tc ? '0 : (N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shd_dig_q <= {N_DIGITS{BLANK_CODE}};
      act_dig_q <= {N_DIGITS{BLANK_CODE}};
      shd_msk_q <= '0;
      act_msk_q <= '0;
      idx_q     <= '0;
      blink_q   <= 1'b0;
      pending_q <= 1'b0;
      code_q    <= BLANK_CODE;
      en_q      <= '0;
      fs_q      <= 1'b0;
    end else begin
      shd_dig_q <= shd_dig_d;
      act_dig_q <= act_dig_d;
      shd_msk_q <= shd_msk_d;
      act_msk_q <= act_msk_d;
      idx_q     <= idx_d;
      blink_q   <= blink_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      en_q      <= en_d;
      fs_q      <= frame_edge;
    end
  end

  assign digit_code_o  = code_q;
  assign digit_en_o    = en_q;
  assign frame_start_o = fs_q;
  assign pending_o     = pending_q;
endmodule

// File: tb/tb_disp_scan_mux.sv
module tb_disp_scan_mux;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [15:0] digits_in_i;
  logic [3:0]  blink_mask_i;
  logic        lzb_en_i;
  logic [3:0]  digit_code_o;
  logic [3:0]  digit_en_o;
  logic        frame_start_o;
  logic        pending_o;

  int checks = 0;
  int errors = 0;

  disp_scan_mux #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_i        (load_i),
    .digits_in_i   (digits_in_i),
    .blink_mask_i  (blink_mask_i),
    .lzb_en_i      (lzb_en_i),
    .digit_code_o  (digit_code_o),
    .digit_en_o    (digit_en_o),
    .frame_start_o (frame_start_o),
    .pending_o     (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] m);
    digits_in_i  = d;
    blink_mask_i = m;
    load_i       = 1'b1;
    step();
    load_i       = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (frame_start_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("fs_seen", {31'd0, frame_start_o}, 32'd1);
  endtask

  // Starts at slot 0 cycle 0, ends at slot 3 cycle 1.
  task automatic read_frame(input string tag, input logic [15:0] exp);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s_code%0d", tag, s), {28'd0, digit_code_o}, {28'd0, exp[4*s +: 4]});
      chk($sformatf("%s_guard%0d", tag, s), {28'd0, digit_en_o}, 32'd0);
      step();
      chk($sformatf("%s_en%0d", tag, s), {28'd0, digit_en_o}, 32'd1 << s);
      if (s < 3) begin
        step();
        step();
        step();
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    load_i = 1'b0;
    digits_in_i = '0;
    blink_mask_i = '0;
    lzb_en_i = 1'b0;

    // 1: reset and scan sequence
    repeat (3) @(negedge clk_i);
    chk("rst_en",   {28'd0, digit_en_o}, 32'd0);
    chk("rst_code", {28'd0, digit_code_o}, 32'hF);
    chk("rst_fs",   {31'd0, frame_start_o}, 32'd0);
    chk("rst_pend", {31'd0, pending_o}, 32'd0);
    rst_i = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      chk($sformatf("scan_en_k%0d", k), {28'd0, digit_en_o},
          ((k % 4) == 0) ? 32'd0 : (32'd1 << ((k / 4) % 4)));
      chk($sformatf("scan_fs_k%0d", k), {31'd0, frame_start_o},
          (k > 0 && (k % 16) == 0) ? 32'd1 : 32'd0);
      if (k < 32) step();
    end

    // 2: basic load and double-buffer latency
    do_load(16'h1234, 4'b0000);
    chk("t2_pend_set", {31'd0, pending_o}, 32'd1);
    wait_fs();
    chk("t2_pend_clr", {31'd0, pending_o}, 32'd0);
    read_frame("t2", 16'h1234);

    // 3: leading-zero blanking
    lzb_en_i = 1'b1;
    do_load(16'h0050, 4'b0000);
    wait_fs();
    read_frame("t3a", 16'hFF50);
    lzb_en_i = 1'b0;
    wait_fs();
    read_frame("t3b", 16'h0050);
    lzb_en_i = 1'b1;
    do_load(16'h0000, 4'b0000);
    wait_fs();
    read_frame("t3c", 16'hFFF0);

    // 4: blink, from a fresh reset so the phase is known
    lzb_en_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    do_load(16'h4321, 4'b0010);
    wait_fs();
    read_frame("t4f1", 16'h4321);
    wait_fs();
    read_frame("t4f2", 16'h43F1);
    wait_fs();
    read_frame("t4f3", 16'h43F1);
    wait_fs();
    read_frame("t4f4", 16'h4321);
    wait_fs();
    read_frame("t4f5", 16'h4321);

    // 5: back-to-back loads, then a load on the frame edge
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    chk("t5_at_last", {28'd0, digit_en_o}, 32'b1000);
    digits_in_i = 16'h3333;
    blink_mask_i = 4'b0000;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    chk("t5_fs",   {31'd0, frame_start_o}, 32'd1);
    chk("t5_pend", {31'd0, pending_o}, 32'd1);
    read_frame("t5a", 16'h2222);
    wait_fs();
    chk("t5_pend_clr", {31'd0, pending_o}, 32'd0);
    read_frame("t5b", 16'h3333);

    // 6: asynchronous reset mid-slot
    wait_fs();
    do_load(16'h9876, 4'b0000);
    repeat (8) step();
    chk("t6_pre_en",   {28'd0, digit_en_o}, 32'b0100);
    chk("t6_pre_pend", {31'd0, pending_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_async_en",   {28'd0, digit_en_o}, 32'd0);
    chk("t6_async_code", {28'd0, digit_code_o}, 32'hF);
    chk("t6_async_fs",   {31'd0, frame_start_o}, 32'd0);
    chk("t6_async_pend", {31'd0, pending_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_fs();
    chk("t6_pend", {31'd0, pending_o}, 32'd0);
    read_frame("t6", 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
